// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
//   Round-robin arbiter and sequencer that shares one DW-bit holding register
//   among NREQ requesters. In IDLE the next requester after the last served one
//   wins. Its word is latched into the holding register, and the design enters
//   HOLD. In HOLD the word is presented downstream with data_valid until one of
//   the following ends the transfer:
//     - data_ack        : completion, pulses done[w]
//     - the winner drops req : abort
//     - TIMEOUT cycles pass  : timeout, pulses timeout_err
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous active-low reset
//   req          per-requester request, held until done[i] or abort
//   wr_data      flat word bus, requester i on bits [i*DW +: DW]
//   gnt          one-hot grant, high for the whole HOLD
//   done         one-cycle completion pulse to the served requester
//   data_out     shared holding register contents
//   data_valid   data_out is a live transfer awaiting ack
//   data_ack     downstream consumed data_out (ignored outside HOLD)
//   busy         transfer in progress (state != IDLE)
//   timeout_err  one-cycle pulse when a HOLD times out
//   xfer_count   acked transfers since reset, wraps 0xFFFF -> 0
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   wr_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 busy,
    output logic                 timeout_err,
    output logic [15:0]          xfer_count
);

    localparam int          PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_INIT = PW'(NREQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t               state_r, state_s;
    logic [PW-1:0]        ptr_r, ptr_s;
    logic [PW-1:0]        win_r, win_s;
    logic [15:0]          cnt_r, cnt_s;
    logic [15:0]          xfer_r, xfer_s;
    logic [DW-1:0]        data_r, data_s;
    logic [NREQ-1:0]      gnt_r, gnt_s;
    logic [NREQ-1:0]      done_r, done_s;
    logic                 valid_r, valid_s;
    logic                 busy_r, busy_s;
    logic                 tmo_r, tmo_s;

    logic [DW-1:0]        words_s [NREQ];
    logic [PW-1:0]        pick_s;
    logic [PW-1:0]        scan_s;
    logic                 found_s;

    // One-hot decode of a requester index.
    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Split the flat word bus into per-requester words.
    for (genvar i = 0; i < NREQ; i++) begin : g_words
        assign words_s[i] = wr_data[i*DW +: DW];
    end

    // Round-robin pick: the first set req scanning ptr+1, ptr+2, ... mod NREQ.
    always_comb begin
        found_s = 1'b0;
        pick_s  = '0;
        scan_s  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_s  = PW'((int'(ptr_r) + k) % NREQ);
            pick_s  = (!found_s && req[scan_s]) ? scan_s : pick_s;
            found_s = found_s | req[scan_s];
        end
    end

    // Next-state and next-output logic. Registered values hold by default,
    // and pulses default low.
    always_comb begin
        state_s = state_r;
        ptr_s   = ptr_r;
        win_s   = win_r;
        cnt_s   = cnt_r;
        xfer_s  = xfer_r;
        data_s  = data_r;
        gnt_s   = gnt_r;
        done_s  = '0;
        valid_s = valid_r;
        tmo_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    // The winner's word is sampled only on this grant edge.
                    win_s   = pick_s;
                    data_s  = words_s[pick_s];
                    gnt_s   = onehot(pick_s);
                    valid_s = 1'b1;
                    cnt_s   = 16'd0;
                    state_s = HOLD;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (data_ack) begin
                    // Ack has priority over abort and timeout on the same edge.
                    done_s  = onehot(win_r);
                    xfer_s  = xfer_r + 16'd1;
                    ptr_s   = win_r;
                    gnt_s   = '0;
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else if (!req[win_r]) begin
                    ptr_s   = win_r;
                    gnt_s   = '0;
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else if (cnt_r == TO_LAST) begin
                    tmo_s   = 1'b1;
                    ptr_s   = win_r;
                    gnt_s   = '0;
                    valid_s = 1'b0;
                    state_s = IDLE;
                end else begin
                    cnt_s   = cnt_r + 16'd1;
                end
            end
            default: begin
                gnt_s   = '0;
                valid_s = 1'b0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == HOLD);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            ptr_r   <= PTR_INIT;
            win_r   <= '0;
            cnt_r   <= 16'd0;
            xfer_r  <= 16'd0;
            data_r  <= '0;
            gnt_r   <= '0;
            done_r  <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            tmo_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            win_r   <= win_s;
            cnt_r   <= cnt_s;
            xfer_r  <= xfer_s;
            data_r  <= data_s;
            gnt_r   <= gnt_s;
            done_r  <= done_s;
            valid_r <= valid_s;
            busy_r  <= busy_s;
            tmo_r   <= tmo_s;
        end
    end

    assign gnt         = gnt_r;
    assign done        = done_r;
    assign data_out    = data_r;
    assign data_valid  = valid_r;
    assign busy        = busy_r;
    assign timeout_err = tmo_r;
    assign xfer_count  = xfer_r;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed bench for reg_write_arbiter (NREQ=4, DW=32, TIMEOUT=4).
//   Inputs are driven and outputs sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [DW-1:0]      data_out;
    logic               data_valid;
    logic               data_ack;
    logic               busy;
    logic               timeout_err;
    logic [15:0]        xfer_count;

    int checks   = 0;
    int failures = 0;

    reg_write_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wr_data     (wr_data),
        .gnt         (gnt),
        .done        (done),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .data_ack    (data_ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .xfer_count  (xfer_count)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; req = 4'b0000; data_ack = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) wr_data[i*DW +: DW] = 32'h1000_0000 + 32'(i);
        reset = 1'b0; req = 4'b1111; data_ack = 1'b0;
        tick(); tick();
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 4'b0000); end
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL reset_done got=%b exp=%b", done, 4'b0000); end
        checks++; if ({data_valid, busy, timeout_err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=%b", {data_valid, busy, timeout_err}, 3'b000); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_out, 32'h0); end
        checks++; if (xfer_count !== 16'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", xfer_count, 16'h0); end
        reset = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL reset_first_gnt got=%b exp=%b", gnt, 4'b0001); end
        checks++; if (data_out !== 32'h1000_0000) begin failures++; $display("FAIL reset_first_data got=%h exp=%h", data_out, 32'h1000_0000); end
    endtask

    task automatic test_single();
        do_reset();
        wr_data[2*DW +: DW] = 32'hDEAD_BEEF;
        req = 4'b0100;
        tick();
        checks++; if ({data_valid, busy} !== 2'b11) begin failures++; $display("FAIL single_valid got=%b exp=%b", {data_valid, busy}, 2'b11); end
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=%b", gnt, 4'b0100); end
        checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_data got=%h exp=%h", data_out, 32'hDEAD_BEEF); end
        tick(); tick();
        checks++; if ({data_valid, done} !== 5'b1_0000) begin failures++; $display("FAIL single_wait got=%b exp=%b", {data_valid, done}, 5'b1_0000); end
        data_ack = 1'b1;
        tick();
        checks++; if (done !== 4'b0100) begin failures++; $display("FAIL single_done got=%b exp=%b", done, 4'b0100); end
        checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL single_count got=%0d exp=%0d", xfer_count, 1); end
        checks++; if ({gnt, data_valid, busy} !== 6'b0) begin failures++; $display("FAIL single_release got=%b exp=%b", {gnt, data_valid, busy}, 6'b0); end
        data_ack = 1'b0; req = 4'b0000;
        tick();
        checks++; if (done !== 4'b0000) begin failures++; $display("FAIL single_done_pulse got=%b exp=%b", done, 4'b0000); end
        checks++; if (data_out !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_retain got=%h exp=%h", data_out, 32'hDEAD_BEEF); end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] exp_seq [5];
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b0100;
        exp_seq[3] = 4'b1000; exp_seq[4] = 4'b0001;
        do_reset();
        req = 4'b1111; data_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (gnt !== exp_seq[i]) begin failures++; $display("FAIL fair_gnt%0d got=%b exp=%b", i, gnt, exp_seq[i]); end
            tick();
            checks++; if (done !== exp_seq[i]) begin failures++; $display("FAIL fair_done%0d got=%b exp=%b", i, done, exp_seq[i]); end
        end
        checks++; if (xfer_count !== 16'd5) begin failures++; $display("FAIL fair_count got=%0d exp=%0d", xfer_count, 5); end
        req = 4'b0000;
        tick();
        checks++; if ({xfer_count, done, busy} !== {16'd5, 4'b0000, 1'b0}) begin failures++; $display("FAIL ack_in_idle got=%h/%b/%b exp=5/0000/0", xfer_count, done, busy); end
        data_ack = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req = 4'b0010;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL tmo_gnt got=%b exp=%b", gnt, 4'b0010); end
        tick(); tick(); tick();
        checks++; if ({timeout_err, data_valid} !== 2'b01) begin failures++; $display("FAIL tmo_early got=%b exp=%b", {timeout_err, data_valid}, 2'b01); end
        tick();
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL tmo_pulse got=%b exp=%b", timeout_err, 1'b1); end
        checks++; if ({done, gnt, data_valid, busy} !== 10'b0) begin failures++; $display("FAIL tmo_release got=%b exp=%b", {done, gnt, data_valid, busy}, 10'b0); end
        checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL tmo_count got=%0d exp=%0d", xfer_count, 0); end
        req = 4'b1111;
        tick();
        checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL tmo_ptr got=%b exp=%b", gnt, 4'b0100); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL tmo_pulse_end got=%b exp=%b", timeout_err, 1'b0); end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_abort_vs_ack();
        do_reset();
        wr_data[3*DW +: DW] = 32'hCAFE_F00D;
        req = 4'b1000;
        tick();
        checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL abort_gnt got=%b exp=%b", gnt, 4'b1000); end
        req = 4'b0000; data_ack = 1'b1;
        tick();
        checks++; if (done !== 4'b1000) begin failures++; $display("FAIL ack_beats_abort got=%b exp=%b", done, 4'b1000); end
        checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL ack_beats_abort_count got=%0d exp=%0d", xfer_count, 1); end
        data_ack = 1'b0;
        wr_data[3*DW +: DW] = 32'h1234_5678;
        req = 4'b1000;
        tick();
        checks++; if (data_out !== 32'h1234_5678) begin failures++; $display("FAIL abort_data got=%h exp=%h", data_out, 32'h1234_5678); end
        wr_data[3*DW +: DW] = 32'hAAAA_5555;
        tick();
        checks++; if (data_out !== 32'h1234_5678) begin failures++; $display("FAIL sample_once got=%h exp=%h", data_out, 32'h1234_5678); end
        req = 4'b0000;
        tick();
        checks++; if ({done, gnt, data_valid, busy} !== 10'b0) begin failures++; $display("FAIL abort_release got=%b exp=%b", {done, gnt, data_valid, busy}, 10'b0); end
        checks++; if (xfer_count !== 16'd1) begin failures++; $display("FAIL abort_count got=%0d exp=%0d", xfer_count, 1); end
        tick();
        checks++; if (data_out !== 32'h1234_5678) begin failures++; $display("FAIL abort_retain got=%h exp=%h", data_out, 32'h1234_5678); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        req = 4'b0001; data_ack = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL b2b_gnt1 got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0011;
        tick();
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL b2b_fair got=%b exp=%b", gnt, 4'b0010); end
        req = 4'b0001;
        tick();
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL b2b_regrant got=%b exp=%b", gnt, 4'b0001); end
        tick();
        checks++; if (xfer_count !== 16'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", xfer_count, 3); end
        req = 4'b0000; data_ack = 1'b0;
        tick();
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr_data[2*DW +: DW] = 32'h5A5A_A5A5;
        req = 4'b0100;
        tick(); tick();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy got=%b exp=%b", busy, 1'b1); end
        reset = 1'b0;
        tick();
        checks++; if ({busy, data_valid, gnt} !== 6'b0) begin failures++; $display("FAIL midrst_state got=%b exp=%b", {busy, data_valid, gnt}, 6'b0); end
        checks++; if (data_out !== 32'h0) begin failures++; $display("FAIL midrst_data got=%h exp=%h", data_out, 32'h0); end
        reset = 1'b1; req = 4'b1111;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL midrst_ptr got=%b exp=%b", gnt, 4'b0001); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        reset = 1'b0; req = '0; wr_data = '0; data_ack = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_abort_vs_ack();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
